vga_frame_capture: RTL
======================

Name: vga_frame_capture

Overview:
Sink-side counterpart of the VGA slideshow driver. It consumes a VGA-style pixel stream (active-low syncs, blank, 8-bit RGB) on the system clock, qualified by a 25 MHz pixel enable. It recovers line and frame timing and checks the stream against the expected active geometry. Once locked, it emits one frame-buffer write per active pixel in 6-bit colour, so the team can loop back and self-check driver output, or capture external video.

Parameters:
H_ACTIVE, 640, expected active pixels per line
V_ACTIVE, 480, expected active lines per frame
LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)
FRAME_TIMEOUT, 420000, pix_en samples without VS falling edge before search restarts

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
pix_en  in  1  pixel-sample strobe, one CLOCK_50 cycle wide
VGA_HS  in  1  horizontal sync, active low
VGA_VS  in  1  vertical sync, active low
VGA_BLANK_N  in  1  high during active video
VGA_R  in  8  red
VGA_G  in  8  green
VGA_B  in  8  blue
wr_en  out  1  frame-buffer write strobe, one cycle
wr_x  out  10  pixel column
wr_y  out  9  pixel row
wr_data  out  6  pixel colour {R[7:6],G[7:6],B[7:6]}
frame_start  out  1  one-cycle pulse at VS falling edge while locked
locked  out  1  capture enabled
err_count  out  8  saturating count of bad frames seen while locked

Behaviour:
- Clock and reset: everything is in the CLOCK_50 domain. Reset is asynchronous and active-high. On reset:
  - all outputs are 0.
  - state is SEARCH; all counters are 0.
  - the previous-sample registers for HS and VS are 1.
- Input sampling:
  - Inputs are sampled only on cycles where pix_en=1. Cycles with pix_en=0 change no state, except that pulse outputs return to 0.
  - Edges are detected between consecutive samples. A falling edge means previous sample 1, current sample 0.
- Pixel counting:
  - An active sample is one with BLANK_N=1.
  - x_cnt counts active samples in the current line and saturates at 1023. It clears on an HS falling edge.
  - line_seen is set by any active sample in the line.
- Line end (HS falling edge):
  - If line_seen=1: line_cnt increments (saturating at 511). If x_cnt != H_ACTIVE, set frame_bad.
  - x_cnt and line_seen then clear.
- Frame end (VS falling edge):
  - good = (frame_bad==0) && (line_cnt==V_ACTIVE).
  - line_cnt, frame_bad, x_cnt and the timeout counter then clear.
- State machine:
  - SEARCH: on a VS falling edge, go to MEASURE with good_cnt=0. That first edge is not evaluated.
  - MEASURE, at frame end:
    - good: good_cnt+1. When it reaches LOCK_FRAMES, go to LOCKED and pulse frame_start on the same edge.
    - bad: good_cnt=0 and stay in MEASURE.
  - LOCKED, at frame end:
    - good: pulse frame_start.
    - bad: go to MEASURE with good_cnt=0, increment err_count (saturating at 255), no frame_start.
  - Timeout: any state other than SEARCH returns to SEARCH when the timeout counter reaches FRAME_TIMEOUT. The counter is 20 bits, increments per pix_en, and clears at frame end. This does not change err_count.
- locked = (state==LOCKED).
- Writes:
  - Only in LOCKED, for an active sample with x_cnt<H_ACTIVE and line_cnt<V_ACTIVE, using the values before the increment.
  - wr_en is high in the cycle after the pix_en sample, for exactly one cycle.
  - wr_x = x_cnt and wr_y = line_cnt, both pre-increment.
  - An out-of-range active sample sets frame_bad immediately and produces no write.
  - wr_x, wr_y and wr_data hold their last value when wr_en=0.
- Simultaneous HS and VS falling edges: line-end processing happens first, then frame-end evaluation uses the updated line_cnt.
- An active sample on the same sample as an HS falling edge counts toward the new line.
- Reset mid-frame: immediate return to SEARCH. No write or pulse is produced in the reset cycle or after it until the stream is relocked.

Test Plan:
- Nominal stream: 800x525 timing, pix_en every 2nd cycle, 4 frames. Required:
  - locked rises at the 3rd VS falling edge (entry edge plus 2 good frames), together with one frame_start.
  - The 4th frame produces exactly 307200 writes: first at (0,0), last at (639,479). wr_data = {R[7:6],G[7:6],B[7:6]}; for example R=8'hC0, G=0, B=8'h40 gives 6'b110001.
  - err_count stays 0.
- Short line: while locked, one line of 639 active pixels. Required: at the next VS fall, locked=0, err_count=1, no frame_start. Relock after 2 further good frames.
- Tall frame: 481 active lines. Required: no write for row 480, err_count increments, lock is lost.
- Timeout: stop VS toggling while locked. Required: locked drops after 420000 pix_en samples, err_count is unchanged, state is SEARCH. Restoring VS needs 3 VS falls to relock.
- Reset mid-frame: assert reset at pixel (100,200). Required: wr_en=0 and locked=0 in the same cycle, with all outputs zero.
- pix_en gating: hold pix_en=0 while the inputs toggle. Required: no counter change and no writes.

Source files
------------

// File: rtl/vga_frame_capture_if.sv
// Frame-buffer write bus driven by vga_frame_capture.
interface vga_frame_capture_if;
  logic       wr_en;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [5:0] wr_data;

  modport master (output wr_en, output wr_x, output wr_y, output wr_data);
  modport slave  (input  wr_en, input  wr_x, input  wr_y, input  wr_data);
endinterface

// File: rtl/vga_frame_capture.sv
// VGA stream sink: recovers line/frame timing, checks geometry, locks, and
// emits one 6-bit frame-buffer write per active pixel while locked.
module vga_frame_capture #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned LOCK_FRAMES   = 2,
  parameter int unsigned FRAME_TIMEOUT = 420000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       pix_en,
  input  logic                       VGA_HS,
  input  logic                       VGA_VS,
  input  logic                       VGA_BLANK_N,
  input  logic [7:0]                 VGA_R,
  input  logic [7:0]                 VGA_G,
  input  logic [7:0]                 VGA_B,
  vga_frame_capture_if.master        fb,
  output logic                       frame_start,
  output logic                       locked,
  output logic [7:0]                 err_count
);

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
  localparam logic [8:0]  V_ACT   = 9'(V_ACTIVE);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);
  localparam logic [19:0] TIMEOUT = 20'(FRAME_TIMEOUT);

  logic [1:0]  state, state_n;
  logic        hs_prev, vs_prev;
  logic [9:0]  x_cnt;
  logic [8:0]  line_cnt;
  logic        line_seen;
  logic        frame_bad;
  logic [19:0] to_cnt;
  logic [3:0]  good_cnt, good_n;
  logic [7:0]  err_n;

  logic        hs_fall, vs_fall, line_end, in_range, oob, do_write, good, fs_n;
  logic [8:0]  line_cnt_le;
  logic        bad_next, seen_base, seen_next;
  logic [9:0]  x_base, x_next;
  logic [19:0] to_inc;

  // Only the top two bits of each colour channel are stored.
  logic unused_colour;
  assign unused_colour = ^{VGA_R[5:0], VGA_G[5:0], VGA_B[5:0]};

  assign locked = (state == S_LOCKED);

  // Line end is resolved first, so a sample that is also an HS fall is
  // counted in the new line and frame evaluation sees the updated line_cnt.
  always_comb begin
    hs_fall     = hs_prev & ~VGA_HS;
    vs_fall     = vs_prev & ~VGA_VS;
    line_end    = hs_fall & line_seen;
    line_cnt_le = (line_end && line_cnt != '1) ? line_cnt + 9'd1 : line_cnt;
    x_base      = hs_fall ? '0 : x_cnt;
    seen_base   = hs_fall ? 1'b0 : line_seen;
    in_range    = (x_base < H_ACT) && (line_cnt_le < V_ACT);
    oob         = VGA_BLANK_N & ~in_range;
    do_write    = VGA_BLANK_N & in_range & (state == S_LOCKED);
    x_next      = (VGA_BLANK_N && x_base != '1) ? x_base + 10'd1 : x_base;
    seen_next   = seen_base | VGA_BLANK_N;
    bad_next    = frame_bad | (line_end && x_cnt != H_ACT) | oob;
    good        = ~bad_next && (line_cnt_le == V_ACT);
    to_inc      = (to_cnt != '1) ? to_cnt + 20'd1 : to_cnt;

    state_n = state;
    good_n  = good_cnt;
    err_n   = err_count;
    fs_n    = 1'b0;
    if (vs_fall) begin
      case (state)
        S_SEARCH: begin
          state_n = S_MEASURE;
          good_n  = '0;
        end
        S_MEASURE: begin
          if (good) begin
            good_n = good_cnt + 4'd1;
            if (good_n == LOCK_N) begin
              state_n = S_LOCKED;
              fs_n    = 1'b1;
            end
          end else begin
            good_n = '0;
          end
        end
        S_LOCKED: begin
          if (good) begin
            fs_n = 1'b1;
          end else begin
            state_n = S_MEASURE;
            good_n  = '0;
            if (err_count != '1) err_n = err_count + 8'd1;
          end
        end
        default: state_n = S_SEARCH;
      endcase
    end else if (state != S_SEARCH && to_inc >= TIMEOUT) begin
      state_n = S_SEARCH;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= S_SEARCH;
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      x_cnt       <= '0;
      line_cnt    <= '0;
      line_seen   <= 1'b0;
      frame_bad   <= 1'b0;
      to_cnt      <= '0;
      good_cnt    <= '0;
      err_count   <= '0;
      frame_start <= 1'b0;
      fb.wr_en    <= 1'b0;
      fb.wr_x     <= '0;
      fb.wr_y     <= '0;
      fb.wr_data  <= '0;
    end else begin
      fb.wr_en    <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hs_prev   <= VGA_HS;
        vs_prev   <= VGA_VS;
        line_seen <= seen_next;
        state     <= state_n;
        good_cnt  <= good_n;
        err_count <= err_n;
        if (vs_fall) begin
          x_cnt     <= '0;
          line_cnt  <= '0;
          frame_bad <= 1'b0;
          to_cnt    <= '0;
        end else begin
          x_cnt     <= x_next;
          line_cnt  <= line_cnt_le;
          frame_bad <= bad_next;
          to_cnt    <= to_inc;
        end
        fb.wr_en    <= do_write;
        frame_start <= fs_n;
        if (do_write) begin
          fb.wr_x    <= x_base;
          fb.wr_y    <= line_cnt_le;
          fb.wr_data <= {VGA_R[7:6], VGA_G[7:6], VGA_B[7:6]};
        end
      end
    end
  end

endmodule
